// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter that shares the UART's asynchronous 8-bit register bus
// between two requesters, generating setup/strobe/hold timed bus cycles.
module uart_bus_arbiter #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    input  logic       req0_we,
    input  logic [3:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_ack,
    output logic [7:0] req0_rdata,

    input  logic       req1_valid,
    input  logic       req1_we,
    input  logic [3:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_ack,
    output logic [7:0] req1_rdata,

    output logic [3:0] AddrBus,
    output logic       n_ChipSelect,
    output logic       n_rd,
    output logic       n_we,
    output logic [7:0] DataBusI,
    input  logic [7:0] DataBusO,

    output logic       busy,
    output logic       grant_id
);

    localparam int unsigned MAX_CYC = (SETUP_CYC > STROBE_CYC)
                                      ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                      : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               cur_we;

    logic               pick1_c;
    logic               sel_we_c;
    logic [3:0]         sel_addr_c;
    logic [7:0]         sel_wdata_c;
    logic               can_grant_c;

    // Winner selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        pick1_c = 1'b0;
        if (req0_valid && req1_valid) begin
            pick1_c = ~last;
        end else begin
            pick1_c = req1_valid;
        end
        sel_we_c    = pick1_c ? req1_we    : req0_we;
        sel_addr_c  = pick1_c ? req1_addr  : req0_addr;
        sel_wdata_c = pick1_c ? req1_wdata : req0_wdata;
        // The ack cycle doubles as the mandatory bus-idle turnaround.
        can_grant_c = (req0_valid || req1_valid) && !req0_ack && !req1_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            last         <= 1'b1;
            cur_we       <= 1'b0;
            req0_ack     <= 1'b0;
            req1_ack     <= 1'b0;
            req0_rdata   <= 8'h00;
            req1_rdata   <= 8'h00;
            AddrBus      <= 4'h0;
            n_ChipSelect <= 1'b1;
            n_rd         <= 1'b1;
            n_we         <= 1'b1;
            DataBusI     <= 8'h00;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
        end else begin
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_grant_c) begin
                        state        <= SETUP;
                        cnt          <= CNT_W'(SETUP_CYC - 1);
                        cur_we       <= sel_we_c;
                        AddrBus      <= sel_addr_c;
                        DataBusI     <= sel_we_c ? sel_wdata_c : 8'h00;
                        n_ChipSelect <= 1'b0;
                        busy         <= 1'b1;
                        grant_id     <= pick1_c;
                        last         <= pick1_c;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        cnt   <= CNT_W'(STROBE_CYC - 1);
                        n_we  <= ~cur_we;
                        n_rd  <= cur_we;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        // Read data is taken at the edge that releases the strobe.
                        if (!cur_we) begin
                            if (grant_id) begin
                                req1_rdata <= DataBusO;
                            end else begin
                                req0_rdata <= DataBusO;
                            end
                        end
                        state <= HOLD;
                        cnt   <= CNT_W'(HOLD_CYC - 1);
                        n_rd  <= 1'b1;
                        n_we  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state        <= IDLE;
                        n_ChipSelect <= 1'b1;
                        AddrBus      <= 4'h0;
                        DataBusI     <= 8'h00;
                        busy         <= 1'b0;
                        if (grant_id) begin
                            req1_ack <= 1'b1;
                        end else begin
                            req0_ack <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
